sig_byte_packer: RTL and testbench
==================================

Name: sig_byte_packer

Overview:
- Downstream consumer of the serial signature ROM, which outputs its selected bit MSB-first on `q` and is steered by `ld`/`en`.
- Drives that ROM's `ld`/`en`, deserialises the bit stream into bytes MSB-first, and presents each byte on a valid/ready handshake.
- Feeds the cipher/UART byte path.
- One frame equals FRAME_BYTES bytes (default 32, the full 256-bit signature "Luke Vassallo Tiny Tapeout 2023.").

Parameters:
- FRAME_BYTES, 32, bytes per frame; legal range 1..32.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, frame request; sampled only in IDLE.
- abort, input, 1, synchronous frame cancel.
- sig_q, input, 1, serial bit from the signature ROM. The ROM output is combinational from its counter; the counter is 0xFF after `ld`.
- sig_ld, output, 1, ROM counter load to 0xFF.
- sig_en, output, 1, ROM counter decrement.
- byte_data, output, 8, assembled byte; first received bit is bit 7.
- byte_valid, output, 1, byte_data is valid.
- byte_ready, input, 1, sink accepts the byte.
- byte_last, output, 1, qualifies the final byte of the frame; meaningful only while byte_valid=1.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; bit_cnt=0; byte_cnt=0; shift register=0.
  - byte_data=0x00; byte_valid=0; byte_last=0; sig_ld=0; sig_en=0; busy=0.
- Outputs: sig_ld, sig_en, byte_valid, byte_last and busy decode from registered state only. byte_data is a register. No combinational path from any input to any output.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: sig_ld=1 for exactly one cycle; clear bit_cnt and byte_cnt; -> SHIFT.
  - SHIFT:
    - sig_en=1 every cycle.
    - Each edge: shreg <= {shreg[6:0], sig_q}; bit_cnt++.
    - On the edge where bit_cnt==7: byte_data <= {shreg[6:0], sig_q}; bit_cnt <= 0; -> PRESENT.
  - PRESENT:
    - sig_en=0, so the ROM holds its next bit; byte_valid=1; byte_last = (byte_cnt==FRAME_BYTES-1).
    - byte_ready=1 with last=0: byte_cnt++; -> SHIFT.
    - byte_ready=1 with last=1: -> IDLE.
    - byte_ready=0: hold; byte_data stable.
- Latency and throughput:
  - start sampled at edge E0 -> sig_ld high in cycle E0..E1.
  - Bits sampled at E2..E9; byte_valid high after E9.
  - Minimum 9 cycles per byte (8 SHIFT + 1 PRESENT) with byte_ready tied high.
- Boundary and priority rules:
  - start outside IDLE is ignored.
  - abort=1 in any non-IDLE state -> IDLE next edge; byte_valid drops; no byte is accepted that cycle even if byte_ready=1. abort beats byte_ready.
  - abort and start together in IDLE: abort wins; stay IDLE.
  - FRAME_BYTES=32: the ROM counter wraps 0x00 -> 0xFF after the final sig_en. This is harmless, because every frame begins with LOAD.
  - Reset mid-frame returns to IDLE immediately. The next frame restarts from signature bit 255 via LOAD.
  - byte_cnt width is 5 bits. It never exceeds FRAME_BYTES-1.

Optional Feature:
- Macro: SIG_PACKER_REPEAT_EN.
- Defined: in PRESENT, acceptance of the last byte goes to LOAD instead of IDLE. Frames repeat continuously until abort or reset; start is needed only once. busy stays 1.
- Undefined: the frame ends in IDLE, and a new start pulse is required.

Test Plan:
- Packer paired with a signature ROM model; reset then start pulse; byte_ready=1 -> bytes 0x4C,0x75,0x6B,0x65 ("Luke") …, byte 31 = 0x2E with byte_last=1; first byte_valid 9 cycles after start; IDLE after, busy=0.
- FRAME_BYTES=4, byte_ready=1 -> exactly 0x4C,0x75,0x6B,0x65; byte_last only on 0x65; sig_en asserted exactly 32 cycles.
- byte_ready held 0 for 20 cycles on first byte -> byte_data stays 0x4C, sig_en=0 throughout, next byte still 0x75 after release.
- abort in SHIFT of byte 3 -> IDLE next edge, byte_valid=0; new start yields 0x4C again; abort+start same cycle in IDLE -> stays IDLE.
- reset_n low mid-PRESENT (async, between edges) -> byte_valid, busy, sig_en, sig_ld go 0 immediately; start afterwards yields 0x4C.
- SIG_PACKER_REPEAT_EN defined, FRAME_BYTES=2 -> stream 0x4C,0x75,0x4C,0x75… with single LOAD cycle between frames, byte_last on each 0x75.

Source files
------------

// File: rtl/sig_byte_packer_if.sv
// Byte-packer bus: ROM steering (sig_q/sig_ld/sig_en), byte valid/ready stream, frame control.
// Latency: none; wiring only.
// Backpressure: byte_ready from the sink; the packer stalls the ROM while a byte is held.
interface sig_byte_packer_if;
  logic       start;
  logic       abort;
  logic       sig_q;
  logic       sig_ld;
  logic       sig_en;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic       busy;

  // Packer side
  modport master (
    input  start, abort, sig_q, byte_ready,
    output sig_ld, sig_en, byte_data, byte_valid, byte_last, busy
  );

  // Environment side (ROM + byte sink + controller)
  modport slave (
    output start, abort, sig_q, byte_ready,
    input  sig_ld, sig_en, byte_data, byte_valid, byte_last, busy
  );
endinterface

// File: rtl/sig_byte_packer.sv
// Steers the serial signature ROM and packs its MSB-first bits into bytes on a valid/ready stream.
// Latency: start at E0 -> sig_ld E0..E1 -> bits sampled E2..E9 -> byte_valid after E9; 9 cycles/byte min.
// Backpressure: byte_ready=0 parks in PRESENT with sig_en=0 so the ROM holds its next bit.
// Optional: SIG_PACKER_REPEAT_EN restarts the frame (via LOAD) after the last byte instead of idling.
module sig_byte_packer #(
  parameter int FRAME_BYTES = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  sig_byte_packer_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PRESENT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  // Only the seven bits collected so far need storing; the eighth arrives
  // on sig_q during the edge that completes the byte.
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       is_last;

  assign is_last = (byte_cnt_q == LAST_IDX);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 5'd0;
      shreg_q     <= 7'd0;
      byte_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      byte_data_q <= byte_data_d;
    end
  end

  // Next-state and datapath update; abort overrides everything, including a pending accept
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    byte_data_d = byte_data_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = LOAD;
        end
        LOAD: begin
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 5'd0;
          state_d    = SHIFT;
        end
        SHIFT: begin
          shreg_d = {shreg_q[5:0], bus.sig_q};
          if (bit_cnt_q == 3'd7) begin
            byte_data_d = {shreg_q, bus.sig_q};
            bit_cnt_d   = 3'd0;
            state_d     = PRESENT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PRESENT: begin
          if (bus.byte_ready) begin
            if (is_last) begin
`ifdef SIG_PACKER_REPEAT_EN
              state_d = LOAD;
`else
              state_d = IDLE;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + 5'd1;
              state_d    = SHIFT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only
  assign bus.sig_ld     = (state_q == LOAD);
  assign bus.sig_en     = (state_q == SHIFT);
  assign bus.byte_valid = (state_q == PRESENT);
  assign bus.byte_last  = (state_q == PRESENT) && is_last;
  assign bus.busy       = (state_q != IDLE);
  assign bus.byte_data  = byte_data_q;

endmodule

// File: tb/tb_sig_byte_packer.sv
// Bench for sig_byte_packer: two instances (32-byte and 4-byte frames) fed by signature ROM models.
// Latency: checks 9-cycle first-byte latency and 9-cycle per-byte throughput.
// Backpressure: stalls, abort, async reset and start/abort priority exercised by hand sequences.
module tb_sig_byte_packer;

  typedef struct {
    int         stall;
    logic [7:0] data;
    logic       last;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] sig_v = "Luke Vassallo Tiny Tapeout 2023.";
  logic [7:0]   cnt32 = 8'h00;
  logic [7:0]   cnt4 = 8'h00;
  int           n_tests = 0;
  int           n_fail = 0;
  int           en32 = 0;
  int           en4 = 0;
  bit           mon4_on = 1'b1;
  exp_t         exp_q[$];
  exp_t         exp4_q[$];
  vec_t         tbl[32];

  sig_byte_packer_if ifc();
  sig_byte_packer_if ifc4();

  sig_byte_packer #(.FRAME_BYTES(32)) dut (.clk(clk), .reset_n(rst_n), .bus(ifc));
  sig_byte_packer #(.FRAME_BYTES(4))  dut4 (.clk(clk), .reset_n(rst_n), .bus(ifc4));

  always #5 clk = ~clk;

  // Signature ROM models: counter loads 0xFF, decrements on en, q is combinational
  always @(posedge clk) begin
    if (ifc.sig_ld) cnt32 <= 8'hFF;
    else if (ifc.sig_en) cnt32 <= cnt32 - 8'd1;
    if (ifc4.sig_ld) cnt4 <= 8'hFF;
    else if (ifc4.sig_en) cnt4 <= cnt4 - 8'd1;
  end
  assign ifc.sig_q  = sig_v[cnt32];
  assign ifc4.sig_q = sig_v[cnt4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: compare at the negedge before each accepting edge
  always @(negedge clk) begin
    if (ifc.sig_en) en32++;
    if (ifc4.sig_en) en4++;
    if (rst_n && ifc.byte_valid && ifc.byte_ready && !ifc.abort) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb32_unexpected: got byte 0x%0h, expected none", ifc.byte_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb32_data", {24'd0, ifc.byte_data}, {24'd0, e.data});
        check("sb32_last", {31'd0, ifc.byte_last}, {31'd0, e.last});
      end
    end
    if (mon4_on && rst_n && ifc4.byte_valid && ifc4.byte_ready && !ifc4.abort) begin
      if (exp4_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb4_unexpected: got byte 0x%0h, expected none", ifc4.byte_data);
      end else begin
        exp_t e;
        e = exp4_q.pop_front();
        check("sb4_data", {24'd0, ifc4.byte_data}, {24'd0, e.data});
        check("sb4_last", {31'd0, ifc4.byte_last}, {31'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic a, input logic r);
    ifc.start = s;  ifc.abort = a;  ifc.byte_ready = r;
    ifc4.start = s; ifc4.abort = a; ifc4.byte_ready = r;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!ifc.byte_valid && k < 40) begin
      tick();
      k++;
    end
    if (!ifc.byte_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wait_valid: got no byte_valid, expected one within 40 cycles");
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"},  {31'd0, ifc.busy},       32'd0);
    check({name, "_valid"}, {31'd0, ifc.byte_valid}, 32'd0);
    check({name, "_en"},    {31'd0, ifc.sig_en},     32'd0);
    check({name, "_ld"},    {31'd0, ifc.sig_ld},     32'd0);
  endtask

  initial begin
    int k;
    int base32;
    int base4;
    exp_t e;

    for (int i = 0; i < 32; i++) begin
      tbl[i].data  = sig_v[255 - 8*i -: 8];
      tbl[i].last  = (i == 31);
      tbl[i].stall = (i == 0) ? 20 : ((i % 5 == 2) ? (i % 3) + 1 : 0);
    end

    // Reset state
    set_in(1'b0, 1'b0, 1'b0);
    #12;
    check_idle("rst");
    check("rst_data", {24'd0, ifc.byte_data}, 32'h00);
    check("rst_last", {31'd0, ifc.byte_last}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Full 32-byte frame (and the 4-byte instance alongside it)
    base32 = en32;
    base4  = en4;
    for (int i = 0; i < 4; i++) begin
      e.data = tbl[i].data;
      e.last = (i == 3);
      exp4_q.push_back(e);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    check("load_ld",   {31'd0, ifc.sig_ld}, 32'd1);
    check("load_busy", {31'd0, ifc.busy},   32'd1);
    check("load_en",   {31'd0, ifc.sig_en}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      e.data = tbl[i].data;
      e.last = tbl[i].last;
      exp_q.push_back(e);
      ifc.byte_ready  = (tbl[i].stall == 0);
      ifc4.byte_ready = (tbl[i].stall == 0);
      wait_valid(k);
      if (i == 0) begin
        check("first_latency", k, 32'd9);
        check("first_byte_L", {24'd0, ifc.byte_data}, 32'h4C);
      end
      if (i == 1) check("byte_period", k, 32'd8);
      for (int s = 0; s < tbl[i].stall; s++) begin
        check("stall_valid", {31'd0, ifc.byte_valid}, 32'd1);
        check("stall_data",  {24'd0, ifc.byte_data}, {24'd0, tbl[i].data});
        check("stall_en",    {31'd0, ifc.sig_en}, 32'd0);
        tick();
      end
      ifc.byte_ready  = 1'b1;
      ifc4.byte_ready = 1'b1;
      tick();
      if (i == 3) begin
        check("f4_en_cycles", en4 - base4, 32'd32);
        check("f4_drained", exp4_q.size(), 32'd0);
`ifndef SIG_PACKER_REPEAT_EN
        check("f4_idle_busy", {31'd0, ifc4.busy}, 32'd0);
`endif
        mon4_on = 1'b0;
      end
    end
    check("f32_en_cycles", en32 - base32, 32'd256);
`ifdef SIG_PACKER_REPEAT_EN
    check("repeat_busy", {31'd0, ifc.busy},   32'd1);
    check("repeat_ld",   {31'd0, ifc.sig_ld}, 32'd1);
`else
    check_idle("frame_end");
`endif
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    tick();

    // Abort while shifting byte 3; start mid-frame ignored
    for (int i = 0; i < 3; i++) begin
      e.data = tbl[i].data;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    set_in(1'b1, 1'b0, 1'b1);
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("abort_pre_drain", exp_q.size(), 32'd0);
    tick();
    tick();
    ifc.start = 1'b1; ifc4.start = 1'b1;
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    check("start_ignored_ld", {31'd0, ifc.sig_ld}, 32'd0);
    check("shift_en",         {31'd0, ifc.sig_en}, 32'd1);
    ifc.abort = 1'b1; ifc4.abort = 1'b1;
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check_idle("abort_shift");

    // Restart yields 'L'; abort beats byte_ready in PRESENT
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    wait_valid(k);
    check("restart_byte", {24'd0, ifc.byte_data}, 32'h4C);
    set_in(1'b0, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check_idle("abort_present");

    // abort + start together in IDLE: stay IDLE
    set_in(1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check("abort_start_busy", {31'd0, ifc.busy},   32'd0);
    check("abort_start_ld",   {31'd0, ifc.sig_ld}, 32'd0);
    tick();
    check("abort_start_busy2", {31'd0, ifc.busy}, 32'd0);

    // Async reset mid-PRESENT
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    wait_valid(k);
    check("pre_reset_byte", {24'd0, ifc.byte_data}, 32'h4C);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_data", {24'd0, ifc.byte_data}, 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    e.data = tbl[0].data;
    e.last = 1'b0;
    exp_q.push_back(e);
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    ifc.start = 1'b0; ifc4.start = 1'b0;
    wait_valid(k);
    check("post_reset_latency", k, 32'd9);
    check("post_reset_byte", {24'd0, ifc.byte_data}, 32'h4C);
    ifc.byte_ready = 1'b1; ifc4.byte_ready = 1'b1;
    tick();
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check("final_drain", exp_q.size(), 32'd0);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
